// File: rtl/dot4x_clock_detect.sv
// dot4x_clock_detect: measures the dot4x period against a reference tick,
// classifies it as NTSC/PAL and flags disagreement with the chip select.
module dot4x_clock_detect #(
  parameter int COUNT_WIDTH = 16,
  parameter int MIN_COUNT   = 30000,
  parameter int MAX_COUNT   = 34500,
  parameter int THRESHOLD   = 32127,
  parameter int CONFIRM     = 4
) (
  input  logic                   clk_dot4x,
  input  logic                   rst,
  input  logic                   ref_tick,
  input  logic [1:0]             chip,
  output logic [COUNT_WIDTH-1:0] meas_count,
  output logic                   meas_strobe,
  output logic                   detected_pal,
  output logic                   valid,
  output logic                   mismatch,
  output logic                   range_err
);
  localparam int SW = $clog2(CONFIRM + 1);
  localparam logic [COUNT_WIDTH-1:0] MIN_C = COUNT_WIDTH'(MIN_COUNT);
  localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [COUNT_WIDTH-1:0] THR_C = COUNT_WIDTH'(THRESHOLD);
  localparam logic [COUNT_WIDTH-1:0] TO_C  = COUNT_WIDTH'(MAX_COUNT + 1);
  localparam logic [SW-1:0]          CONF_C = SW'(CONFIRM);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, edge_q, edge_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, meas_count_q, meas_count_d;
  logic [SW-1:0]          streak_q, streak_d, streak_nx;
  logic                   cand_q, cand_d, meas_strobe_q, meas_strobe_d;
  logic                   detected_pal_q, detected_pal_d, valid_q, valid_d;
  logic                   mismatch_q, mismatch_d, range_err_q, range_err_d;
  logic                   in_range, cls;
  logic                   chip_unused;

  assign chip_unused = chip[1];

  always_comb begin
    sync1_d        = ref_tick;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    edge_d         = sync2_q & ~prev_q;
    cnt_d          = edge_q ? COUNT_WIDTH'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    in_range       = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
    cls            = cnt_q < THR_C;
    streak_nx      = (cls == cand_q) ? ((streak_q >= CONF_C) ? CONF_C : streak_q + 1'b1) : SW'(1);
    state_d        = state_q;
    streak_d       = streak_q;
    cand_d         = cand_q;
    meas_count_d   = meas_count_q;
    meas_strobe_d  = 1'b0;
    range_err_d    = 1'b0;
    detected_pal_d = detected_pal_q;
    valid_d        = valid_q;
    mismatch_d     = valid_q & (detected_pal_q ^ chip[0]);
    if (state_q == WAIT_FIRST) begin
      state_d = edge_q ? MEASURE : WAIT_FIRST;
    end else if (edge_q) begin
      meas_count_d  = cnt_q;
      meas_strobe_d = 1'b1;
      if (!in_range) begin
        range_err_d = 1'b1;
        streak_d    = '0;
        valid_d     = 1'b0;
        state_d     = MEASURE;
      end else begin
        cand_d   = cls;
        streak_d = streak_nx;
        if (streak_nx == CONF_C) begin
          detected_pal_d = cls;
          valid_d        = 1'b1;
          state_d        = LOCKED;
        end else if (state_q == LOCKED) begin
          valid_d = 1'b0;
          state_d = MEASURE;
        end
      end
    end else if (cnt_q == TO_C) begin
      // reference lost: report once, then wait for a fresh first edge
      range_err_d = 1'b1;
      valid_d     = 1'b0;
      streak_d    = '0;
      state_d     = WAIT_FIRST;
    end
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      state_q        <= WAIT_FIRST;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      edge_q         <= 1'b0;
      cnt_q          <= '0;
      streak_q       <= '0;
      cand_q         <= 1'b0;
      meas_count_q   <= '0;
      meas_strobe_q  <= 1'b0;
      detected_pal_q <= 1'b0;
      valid_q        <= 1'b0;
      mismatch_q     <= 1'b0;
      range_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      edge_q         <= edge_d;
      cnt_q          <= cnt_d;
      streak_q       <= streak_d;
      cand_q         <= cand_d;
      meas_count_q   <= meas_count_d;
      meas_strobe_q  <= meas_strobe_d;
      detected_pal_q <= detected_pal_d;
      valid_q        <= valid_d;
      mismatch_q     <= mismatch_d;
      range_err_q    <= range_err_d;
    end
  end

  assign meas_count   = meas_count_q;
  assign meas_strobe  = meas_strobe_q;
  assign detected_pal = detected_pal_q;
  assign valid        = valid_q;
  assign mismatch     = mismatch_q;
  assign range_err    = range_err_q;
endmodule

// File: doc/dot4x_clock_detect.md
# dot4x_clock_detect

- Measures the period of the running dot4x clock against an external low-rate reference tick.
- Classifies the clock as NTSC (32.727 MHz) or PAL (31.527 MHz) and reports whether that class agrees with the configured `chip[0]` mux select.
- Sits downstream of the dot4x clock generator/mux. It lets the design detect an oscillator that does not match the selected chip model, or a missing reference.
- Runs entirely in the `clk_dot4x` domain.

## Interface

Parameters:
- `COUNT_WIDTH`, 16: width of the period counter and of `meas_count`.
- `MIN_COUNT`, 30000: smallest period accepted as in range.
- `MAX_COUNT`, 34500: largest period accepted as in range. The reference-lost timeout fires at `MAX_COUNT+1`.
- `THRESHOLD`, 32127: a period below this value classifies as PAL; otherwise NTSC.
- `CONFIRM`, 4: number of consecutive agreeing in-range measurements needed before `valid` rises.

Ports:
- `clk_dot4x`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `ref_tick`, in, 1: asynchronous reference. It is nominally a 1 kHz square wave. Only rising edges are used.
- `chip`, in, 2: configured chip model. Only bit 0 is used (1 = PAL).
- `meas_count`, out, `COUNT_WIDTH`: most recent period in `clk_dot4x` cycles.
- `meas_strobe`, out, 1: single-cycle pulse when `meas_count` is updated.
- `detected_pal`, out, 1: confirmed class (1 = PAL).
- `valid`, out, 1: `detected_pal` is confirmed and the reference is present.
- `mismatch`, out, 1: `valid & (detected_pal != chip[0])`, registered.
- `range_err`, out, 1: single-cycle pulse when a measurement is out of range or the reference is lost.

## Operation

Edge detection:
- `ref_tick` passes through a 2-flop synchronizer, then a previous-value flop.
- `edge` = sync2 & ~prev, registered.

Counter `cnt` (`COUNT_WIDTH` bits):
- On a cycle with `edge`, `cnt` is loaded with 1.
- Otherwise `cnt` increments, saturating at all-ones.
- As a result, when `edge` occurs, `cnt` equals the number of cycles since the previous `edge`.

State machine:
- WAIT_FIRST (reset state):
  - The first `edge` only restarts `cnt`. No measurement is produced.
  - Next state: MEASURE.
- MEASURE and LOCKED, on `edge`:
  - `meas_count` <= `cnt`; `meas_strobe` pulses.
  - Out of range (`cnt < MIN_COUNT` or `cnt > MAX_COUNT`): `range_err` pulses, `streak` <= 0, `valid` <= 0, next state MEASURE.
  - In range, class = (`cnt < THRESHOLD`).
  - If class == `cand`, `streak` <= min(`streak`+1, `CONFIRM`). Otherwise `cand` <= class and `streak` <= 1.
  - When the new `streak` equals `CONFIRM`: `detected_pal` <= `cand`, `valid` <= 1, next state LOCKED.
  - In LOCKED, a disagreeing in-range measurement sets `valid` <= 0 and returns to MEASURE. `detected_pal` holds its last confirmed value.
- Timeout, any state except WAIT_FIRST:
  - Fires when `cnt == MAX_COUNT+1` with no `edge` on that cycle.
  - Effects: `range_err` pulses, `valid` <= 0, `streak` <= 0, next state WAIT_FIRST.
  - It fires once, because the next state is WAIT_FIRST.

Precedence and boundaries:
- `edge` on the same cycle as the timeout count: `edge` wins and is treated as an out-of-range measurement.
- `cnt == THRESHOLD` classifies as NTSC.
- `cnt == MIN_COUNT` and `cnt == MAX_COUNT` are both in range.

`mismatch`:
- Registered from the current `valid`, `detected_pal` and `chip[0]`.
- A change on `chip[0]` appears on `mismatch` one cycle later.

Reset values:
- `meas_count`=0, `meas_strobe`=0, `detected_pal`=0, `valid`=0, `mismatch`=0, `range_err`=0.
- `cnt`=0, `streak`=0, `cand`=0.
- Synchronizer flops = 0. State = WAIT_FIRST.

## Timing

- `ref_tick` rising to `edge`: 3 cycles (2 sync flops plus the edge flop), with ±1 cycle of metastability uncertainty.
- `edge` to `meas_strobe`, `meas_count`, `range_err`, `valid` and `detected_pal`: 1 cycle.
- `valid` to `mismatch`: 1 cycle.
- Assertion of `rst` mid-measurement clears everything asynchronously. After release, the first edge is discarded.
- Lock latency from reset release: `CONFIRM`+1 reference edges.

## Test plan

- Ticks every 32727 cycles:
  - `meas_count`=32727 on each strobe.
  - `valid`=1 and `detected_pal`=0 one cycle after the 5th edge.
  - With `chip[0]`=1, `mismatch`=1 one cycle after that.
- Ticks every 31527 cycles with `chip[0]`=1: `detected_pal`=1, `valid`=1 after the 5th edge, `mismatch` stays 0.
- Locked NTSC, then one period of 31527:
  - `valid` falls and `detected_pal` holds 0.
  - Three more 31527 periods (four PAL periods in total) lock PAL again.
- Boundary periods:
  - 30000 and 34500: accepted, no `range_err`.
  - 29999 and 34501: `range_err` pulses, `streak` clears.
  - 32127: classified NTSC. 32126: classified PAL.
- Locked, then `ref_tick` held low:
  - `range_err` pulses exactly once, 34501 cycles after the last edge.
  - `valid`=0, state WAIT_FIRST.
  - The next edge produces no strobe.
- `rst` pulsed after 2 agreeing measurements:
  - All outputs return to reset values.
  - Relock requires 5 fresh edges.
